operand_stack: RTL and testbench
================================

Name: operand_stack

Overview:
- Hardware operand stack that feeds the ALU in the stack processor.
- Holds up to DEPTH data words and applies one stack-pointer operation per accepted op: DES_2, DES_1, ADV_0 or ADV_1, all encoded in package definitions.
- Presents top-of-stack (TOS) and next-on-stack (NOS) as ALU operands A/B and absorbs the ALU result or a pushed immediate.
- Illegal ops move it into a sticky FAULT state until software clears it.

Parameters:
- W, 8, data word width.
- DEPTH, 16, number of stack entries; must be a power of 2 and at least 4.

Ports:
- CLK  in  1  the single clock.
- reset  in  1  synchronous, active-high.
- op_valid  in  1  an op is presented this cycle.
- op_ready  out  1  the stack accepts ops; high only in RUN.
- sp_op  in  2  DES_2/DES_1/ADV_0/ADV_1 from the definitions package.
- wr_en  in  1  write wr_data into the slot that becomes TOS.
- wr_data  in  W  ALU result or immediate.
- clear_fault  in  1  return from FAULT to RUN.
- tos  out  W  registered TOS (ALU A).
- nos  out  W  registered NOS (ALU B).
- depth  out  $clog2(DEPTH)+1  number of valid entries.
- empty  out  1  depth==0.
- full  out  1  depth==DEPTH.
- fault  out  1  state==FAULT.
- fault_code  out  2  last violation: 0 none, 1 overflow, 2 underflow, 3 write-on-empty.

Behaviour:
- Storage is mem[0..DEPTH-1]; depth counts valid entries; TOS is mem[depth-1], NOS is mem[depth-2].
- An op is accepted when op_valid && op_ready.
- ADV_1: legal if depth<DEPTH. If wr_en, mem[depth] <= wr_data. depth+1.
- ADV_0: depth unchanged. If wr_en, legal only if depth>=1, and mem[depth-1] <= wr_data. With wr_en=0 it is always legal (no-op).
- DES_1: legal if depth>=2. If wr_en, mem[depth-2] <= wr_data (binary-op result replaces NOS). depth-1.
- DES_2: legal if depth>=2. depth-2. wr_en is ignored.
- Violation codes:
  - ADV_1 at full -> code 1.
  - DES_1 or DES_2 with depth<2 -> code 2.
  - ADV_0 with wr_en at depth 0 -> code 3.
- On a violation: mem and depth are unchanged; next cycle state=FAULT and fault_code is latched.
- FSM:
  - RUN -> FAULT on an illegal accepted op.
  - FAULT -> RUN on clear_fault.
  - In FAULT, op_ready=0 and op_valid is ignored.
  - clear_fault in RUN has no effect; fault_code keeps its last value until the next violation.
- Latency: tos, nos, depth, empty and full reflect an accepted op on the next rising CLK edge; all outputs are registered. Entries that are not valid read as 0: tos=0 when depth==0, nos=0 when depth<2.
- Depth arithmetic is unsigned and never wraps; the legality checks guarantee 0<=depth<=DEPTH.
- Reset (also mid-operation, including in FAULT):
  - depth=0, state=RUN, tos=0, nos=0, fault_code=0, empty=1, full=0, op_ready=1.
  - mem contents are not cleared.
- reset has priority over every other input in the same cycle.

Optional Feature:
- Macro: OPSTACK_HWM_EN.
- Defined: adds output hwm [$clog2(DEPTH)+1]. It is a registered high-water mark of depth, updated the cycle after depth rises above it, cleared by reset, and not affected by clear_fault.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package definitions already holds the sp_op constants DES_2/DES_1/ADV_0/ADV_1.
- Add to the package:
  - typedef enum logic {ST_RUN, ST_FAULT} stk_state.
  - Constants FLT_NONE=2'd0, FLT_OVF=2'd1, FLT_UNF=2'd2, FLT_WEMPTY=2'd3.
- Sub-module stack_mem: DEPTH x W storage with one write port and two combinational read ports (addresses depth-1 and depth-2). Legality checks, FSM and registered outputs stay in operand_stack.

Test Plan:
- Reset, then ADV_1 wr_en with 8'h05, then ADV_1 wr_en with 8'h03 -> tos=03, nos=05, depth=2, empty=0.
- From that state, DES_1 wr_en with 8'h08 (the ADD result) -> tos=08, nos=0, depth=1; then ADV_0 wr_en with 8'h10 -> tos=10, depth=1.
- 16 pushes of values 1..16 -> full=1, tos=16, nos=15. A 17th ADV_1 -> fault=1, fault_code=1, op_ready=0, depth stays 16. Ops presented during FAULT are ignored. clear_fault -> op_ready=1, depth=16.
- At depth=1, DES_2 -> fault_code=2, depth=1, tos unchanged. At depth=0, ADV_0 wr_en -> fault_code=3.
- Push 3 values, DES_2 -> depth=1, tos=first value. Assert reset together with op_valid -> depth=0, tos=0, fault=0, op_ready=1 the next cycle.
- With OPSTACK_HWM_EN: push 5, pop 3, push 1 -> hwm=5, depth=3. After reset -> hwm=0.

Source files
------------

// File: rtl/definitions.sv
// Shared definitions for the stack processor operand stack:
// stack-pointer op codes, FSM state type and fault codes.
package definitions;

    localparam logic [1:0] DES_2 = 2'd0;
    localparam logic [1:0] DES_1 = 2'd1;
    localparam logic [1:0] ADV_0 = 2'd2;
    localparam logic [1:0] ADV_1 = 2'd3;

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } stk_state;

    localparam logic [1:0] FLT_NONE   = 2'd0;
    localparam logic [1:0] FLT_OVF    = 2'd1;
    localparam logic [1:0] FLT_UNF    = 2'd2;
    localparam logic [1:0] FLT_WEMPTY = 2'd3;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x W operand storage: one synchronous write port and two
// combinational read ports (TOS and NOS addresses).
module stack_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    output logic [W-1:0]  rdata_a,
    output logic [W-1:0]  rdata_b
);

    logic [W-1:0] mem [DEPTH];

    // Storage write; contents survive reset by design.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/operand_stack.sv
// Operand stack feeding the ALU: registered TOS/NOS, depth tracking,
// sticky fault FSM. Optional OPSTACK_HWM_EN adds a depth high-water mark.
module operand_stack
    import definitions::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [1:0]                 sp_op,
    input  logic                       wr_en,
    input  logic [W-1:0]               wr_data,
    input  logic                       clear_fault,
    output logic [W-1:0]               tos,
    output logic [W-1:0]               nos,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       empty,
    output logic                       full,
    output logic                       fault,
`ifdef OPSTACK_HWM_EN
    output logic [1:0]                 fault_code,
    output logic [$clog2(DEPTH):0]     hwm
`else
    output logic [1:0]                 fault_code
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    localparam logic [DW-1:0] D_ZERO = '0;
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_TWO  = DW'(2);
    localparam logic [DW-1:0] D_FULL = DW'(DEPTH);
    localparam logic [AW-1:0] A_ONE  = AW'(1);
    localparam logic [AW-1:0] A_TWO  = AW'(2);

    stk_state        state_q, state_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic [W-1:0]    tos_q, tos_d;
    logic [W-1:0]    nos_q, nos_d;
    logic [1:0]      fault_code_q, fault_code_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic            fault_q, fault_d;
    logic            op_ready_q, op_ready_d;

    logic            accept;
    logic            viol;
    logic [1:0]      viol_code;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [AW-1:0]   ra_tos, ra_nos;
    logic [W-1:0]    rd_tos, rd_nos;

    stack_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .CLK     (CLK),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (wr_data),
        .raddr_a (ra_tos),
        .raddr_b (ra_nos),
        .rdata_a (rd_tos),
        .rdata_b (rd_nos)
    );

    // Decode the accepted op: legality, write slot and next depth.
    always_comb begin
        accept    = op_valid && (state_q == ST_RUN);
        viol      = 1'b0;
        viol_code = FLT_NONE;
        mem_we    = 1'b0;
        mem_waddr = depth_q[AW-1:0];
        depth_d   = depth_q;
        if (accept) begin
            case (sp_op)
                ADV_1: begin
                    if (depth_q == D_FULL) begin
                        viol      = 1'b1;
                        viol_code = FLT_OVF;
                    end else begin
                        mem_we    = wr_en;
                        mem_waddr = depth_q[AW-1:0];
                        depth_d   = depth_q + D_ONE;
                    end
                end
                ADV_0: begin
                    if (wr_en) begin
                        if (depth_q == D_ZERO) begin
                            viol      = 1'b1;
                            viol_code = FLT_WEMPTY;
                        end else begin
                            mem_we    = 1'b1;
                            mem_waddr = depth_q[AW-1:0] - A_ONE;
                        end
                    end
                end
                DES_1: begin
                    if (depth_q < D_TWO) begin
                        viol      = 1'b1;
                        viol_code = FLT_UNF;
                    end else begin
                        mem_we    = wr_en;
                        mem_waddr = depth_q[AW-1:0] - A_TWO;
                        depth_d   = depth_q - D_ONE;
                    end
                end
                DES_2: begin
                    if (depth_q < D_TWO) begin
                        viol      = 1'b1;
                        viol_code = FLT_UNF;
                    end else begin
                        depth_d   = depth_q - D_TWO;
                    end
                end
                default: begin
                end
            endcase
        end
        // Reset overrides any op presented in the same cycle.
        if (reset) begin
            mem_we  = 1'b0;
            viol    = 1'b0;
            depth_d = D_ZERO;
        end
    end

    // Next FSM state plus next TOS/NOS seen through this cycle's write.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        case (state_q)
            ST_RUN: begin
                if (viol) begin
                    state_d      = ST_FAULT;
                    fault_code_d = viol_code;
                end
            end
            ST_FAULT: begin
                if (clear_fault) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        ra_tos = depth_d[AW-1:0] - A_ONE;
        ra_nos = depth_d[AW-1:0] - A_TWO;
        if (depth_d == D_ZERO) begin
            tos_d = '0;
        end else if (mem_we && (mem_waddr == ra_tos)) begin
            tos_d = wr_data;
        end else begin
            tos_d = rd_tos;
        end
        if (depth_d < D_TWO) begin
            nos_d = '0;
        end else if (mem_we && (mem_waddr == ra_nos)) begin
            nos_d = wr_data;
        end else begin
            nos_d = rd_nos;
        end
        empty_d    = (depth_d == D_ZERO);
        full_d     = (depth_d == D_FULL);
        fault_d    = (state_d == ST_FAULT);
        op_ready_d = (state_d == ST_RUN);
    end

    // Fault FSM with its registered status outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= ST_RUN;
            fault_code_q <= FLT_NONE;
            fault_q      <= 1'b0;
            op_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            fault_code_q <= fault_code_d;
            fault_q      <= fault_d;
            op_ready_q   <= op_ready_d;
        end
    end

    // Depth and operand registers.
    always_ff @(posedge CLK) begin
        if (reset) begin
            depth_q <= D_ZERO;
            tos_q   <= '0;
            nos_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            depth_q <= depth_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

`ifdef OPSTACK_HWM_EN
    logic [DW-1:0] hwm_q, hwm_d;

    // High-water mark trails the registered depth by one cycle.
    always_comb begin
        hwm_d = (depth_q > hwm_q) ? depth_q : hwm_q;
    end

    // High-water mark register; untouched by clear_fault.
    always_ff @(posedge CLK) begin
        if (reset) begin
            hwm_q <= D_ZERO;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

    assign tos        = tos_q;
    assign nos        = nos_q;
    assign depth      = depth_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign op_ready   = op_ready_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed bench for operand_stack: vector table plus multi-cycle
// sequences (fill to full, fault/clear, reset mid-op, optional hwm).
module tb_operand_stack;
    import definitions::*;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [1:0] sp_op = DES_2;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       clear_fault = 1'b0;
    logic [7:0] tos;
    logic [7:0] nos;
    logic [4:0] depth;
    logic       empty;
    logic       full;
    logic       fault;
    logic [1:0] fault_code;
`ifdef OPSTACK_HWM_EN
    logic [4:0] hwm;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    operand_stack #(.W(8), .DEPTH(16)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .sp_op       (sp_op),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .clear_fault (clear_fault),
        .tos         (tos),
        .nos         (nos),
        .depth       (depth),
        .empty       (empty),
        .full        (full),
        .fault       (fault),
`ifdef OPSTACK_HWM_EN
        .fault_code  (fault_code),
        .hwm         (hwm)
`else
        .fault_code  (fault_code)
`endif
    );

    typedef struct packed {
        logic       rs;
        logic       ov;
        logic [1:0] op;
        logic       we;
        logic [7:0] wd;
        logic       cf;
        logic [7:0] e_tos;
        logic [7:0] e_nos;
        logic [4:0] e_depth;
        logic       e_empty;
        logic       e_full;
        logic       e_fault;
        logic [1:0] e_code;
        logic       e_ready;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rs, input logic ov,
                        input logic [1:0] op, input logic we,
                        input logic [7:0] wd, input logic cf);
        reset       = rs;
        op_valid    = ov;
        sp_op       = op;
        wr_en       = we;
        wr_data     = wd;
        clear_fault = cf;
        @(posedge CLK);
        #1;
        reset       = 1'b0;
        op_valid    = 1'b0;
        wr_en       = 1'b0;
        clear_fault = 1'b0;
    endtask

    task automatic push(input logic [7:0] v);
        step(1'b0, 1'b1, ADV_1, 1'b1, v, 1'b0);
    endtask

    initial begin
        //          rs ov op     we wd     cf tos    nos    dep   e  f  flt code r
        tbl[0]  = '{1, 0, DES_2, 0, 8'h00, 0, 8'h00, 8'h00, 5'd0, 1, 0, 0, 2'd0, 1};
        tbl[1]  = '{0, 1, ADV_1, 1, 8'h05, 0, 8'h05, 8'h00, 5'd1, 0, 0, 0, 2'd0, 1};
        tbl[2]  = '{0, 1, ADV_1, 1, 8'h03, 0, 8'h03, 8'h05, 5'd2, 0, 0, 0, 2'd0, 1};
        tbl[3]  = '{0, 1, DES_1, 1, 8'h08, 0, 8'h08, 8'h00, 5'd1, 0, 0, 0, 2'd0, 1};
        tbl[4]  = '{0, 1, ADV_0, 1, 8'h10, 0, 8'h10, 8'h00, 5'd1, 0, 0, 0, 2'd0, 1};
        tbl[5]  = '{0, 1, DES_2, 0, 8'h00, 0, 8'h10, 8'h00, 5'd1, 0, 0, 1, 2'd2, 0};
        tbl[6]  = '{0, 1, ADV_1, 1, 8'h55, 0, 8'h10, 8'h00, 5'd1, 0, 0, 1, 2'd2, 0};
        tbl[7]  = '{0, 0, DES_2, 0, 8'h00, 1, 8'h10, 8'h00, 5'd1, 0, 0, 0, 2'd2, 1};
        tbl[8]  = '{0, 1, ADV_1, 1, 8'h20, 0, 8'h20, 8'h10, 5'd2, 0, 0, 0, 2'd2, 1};
        tbl[9]  = '{0, 1, DES_2, 1, 8'hAA, 0, 8'h00, 8'h00, 5'd0, 1, 0, 0, 2'd2, 1};
        tbl[10] = '{0, 1, ADV_0, 1, 8'h77, 0, 8'h00, 8'h00, 5'd0, 1, 0, 1, 2'd3, 0};
        tbl[11] = '{0, 1, ADV_1, 1, 8'h66, 1, 8'h00, 8'h00, 5'd0, 1, 0, 0, 2'd3, 1};
        tbl[12] = '{0, 0, DES_2, 0, 8'h00, 1, 8'h00, 8'h00, 5'd0, 1, 0, 0, 2'd3, 1};
        tbl[13] = '{0, 1, ADV_0, 0, 8'h44, 0, 8'h00, 8'h00, 5'd0, 1, 0, 0, 2'd3, 1};
        tbl[14] = '{0, 1, ADV_1, 0, 8'h00, 0, 8'h10, 8'h00, 5'd1, 0, 0, 0, 2'd3, 1};
        tbl[15] = '{0, 1, DES_1, 0, 8'h00, 0, 8'h10, 8'h00, 5'd1, 0, 0, 1, 2'd2, 0};

        #2;
        for (int i = 0; i < NV; i++) begin
            step(tbl[i].rs, tbl[i].ov, tbl[i].op, tbl[i].we,
                 tbl[i].wd, tbl[i].cf);
            cmp($sformatf("v%0d.tos", i), int'(tos), int'(tbl[i].e_tos));
            cmp($sformatf("v%0d.nos", i), int'(nos), int'(tbl[i].e_nos));
            cmp($sformatf("v%0d.depth", i), int'(depth), int'(tbl[i].e_depth));
            cmp($sformatf("v%0d.empty", i), int'(empty), int'(tbl[i].e_empty));
            cmp($sformatf("v%0d.full", i), int'(full), int'(tbl[i].e_full));
            cmp($sformatf("v%0d.fault", i), int'(fault), int'(tbl[i].e_fault));
            cmp($sformatf("v%0d.code", i), int'(fault_code), int'(tbl[i].e_code));
            cmp($sformatf("v%0d.ready", i), int'(op_ready), int'(tbl[i].e_ready));
        end

        // Fill to full, overflow, ignored ops in FAULT, clear.
        step(1'b1, 1'b0, DES_2, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
        end
        cmp("fill.full", int'(full), 1);
        cmp("fill.tos", int'(tos), 16);
        cmp("fill.nos", int'(nos), 15);
        cmp("fill.depth", int'(depth), 16);
        push(8'h11);
        cmp("ovf.fault", int'(fault), 1);
        cmp("ovf.code", int'(fault_code), 1);
        cmp("ovf.ready", int'(op_ready), 0);
        cmp("ovf.depth", int'(depth), 16);
        cmp("ovf.tos", int'(tos), 16);
        step(1'b0, 1'b1, ADV_0, 1'b1, 8'h99, 1'b0);
        cmp("ign.tos", int'(tos), 16);
        cmp("ign.depth", int'(depth), 16);
        step(1'b0, 1'b1, DES_2, 1'b0, 8'h00, 1'b0);
        cmp("ign2.depth", int'(depth), 16);
        cmp("ign2.fault", int'(fault), 1);
        step(1'b0, 1'b0, DES_2, 1'b0, 8'h00, 1'b1);
        cmp("clr.ready", int'(op_ready), 1);
        cmp("clr.fault", int'(fault), 0);
        cmp("clr.depth", int'(depth), 16);
        cmp("clr.code", int'(fault_code), 1);
        step(1'b0, 1'b1, DES_2, 1'b0, 8'h00, 1'b0);
        cmp("pop2.depth", int'(depth), 14);
        cmp("pop2.tos", int'(tos), 14);
        cmp("pop2.nos", int'(nos), 13);
        cmp("pop2.full", int'(full), 0);

        // Push 3, drop 2, then reset alongside a valid op.
        step(1'b1, 1'b0, DES_2, 1'b0, 8'h00, 1'b0);
        push(8'h0A);
        push(8'h0B);
        push(8'h0C);
        step(1'b0, 1'b1, DES_2, 1'b0, 8'h00, 1'b0);
        cmp("drop.depth", int'(depth), 1);
        cmp("drop.tos", int'(tos), 8'h0A);
        cmp("drop.nos", int'(nos), 0);
        step(1'b1, 1'b1, ADV_1, 1'b1, 8'hEE, 1'b0);
        cmp("rst.depth", int'(depth), 0);
        cmp("rst.tos", int'(tos), 0);
        cmp("rst.fault", int'(fault), 0);
        cmp("rst.ready", int'(op_ready), 1);
        cmp("rst.empty", int'(empty), 1);

        // Reset while in FAULT clears the fault code.
        step(1'b0, 1'b1, DES_2, 1'b0, 8'h00, 1'b0);
        cmp("unf0.code", int'(fault_code), 2);
        cmp("unf0.ready", int'(op_ready), 0);
        step(1'b1, 1'b0, DES_2, 1'b0, 8'h00, 1'b0);
        cmp("rstf.fault", int'(fault), 0);
        cmp("rstf.code", int'(fault_code), 0);
        cmp("rstf.ready", int'(op_ready), 1);

`ifdef OPSTACK_HWM_EN
        // High-water mark: push 5, pop 3, push 1.
        for (int i = 1; i <= 5; i++) begin
            push(8'(i));
        end
        step(1'b0, 1'b1, DES_2, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, DES_1, 1'b0, 8'h00, 1'b0);
        push(8'h33);
        cmp("hwm.val", int'(hwm), 5);
        cmp("hwm.depth", int'(depth), 3);
        step(1'b1, 1'b0, DES_2, 1'b0, 8'h00, 1'b0);
        cmp("hwm.rst", int'(hwm), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
